// File: rtl/mdu_hilo_if.sv
// Operand, command and result bundle between the EX stage and the MIPS multiply/divide unit.
// The EX stage drives the command side (master).
// The MDU returns Busy and the architectural HI/LO values (slave).
interface mdu_hilo_if;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu_hilo.sv
// MIPS multiply/divide unit that owns the architectural HI/LO registers.
//
// A multiply or divide result is computed in the same cycle the op is accepted.
// That result is parked in a pending register.
// It is committed to HI/LO only when the latency countdown expires, which models
// fixed multi-cycle hardware so the hazard unit can stall on Busy.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 9-12).
// These ops accumulate into {HI,LO}. With the macro undefined they behave as NOPs.
module mdu_hilo #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;

  logic [63:0]        aSext, bSext, aZext, bZext;
  logic [63:0]        sProd, uProd;
  logic signed [63:0] sDivisor;
  logic [63:0]        uDivisor;
  logic [31:0]        sQuot, sRem, uQuot, uRem;

  // Operands are extended to 64 bits so that -2^31 / -1 cannot overflow.
  // The divisor is forced to 1 when B is zero; that result is never used,
  // because a divide by zero keeps HI/LO instead.
  assign aSext    = {{32{bus.A[31]}}, bus.A};
  assign bSext    = {{32{bus.B[31]}}, bus.B};
  assign aZext    = {32'h0, bus.A};
  assign bZext    = {32'h0, bus.B};
  assign sProd    = $signed(aSext) * $signed(bSext);
  assign uProd    = aZext * bZext;
  assign sDivisor = (bus.B == 32'h0) ? 64'sd1 : $signed(bSext);
  assign uDivisor = (bus.B == 32'h0) ? 64'd1 : bZext;
  assign sQuot    = 32'($signed(aSext) / sDivisor);
  assign sRem     = 32'($signed(aSext) % sDivisor);
  assign uQuot    = 32'(aZext / uDivisor);
  assign uRem     = 32'(aZext % uDivisor);

  assign bus.Busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // State, countdown, pending result and HI/LO registers; reset aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  // Accept a new op when idle, count down while running, and commit the pending result on the final count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            4'd1: begin
              pend_d  = sProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            4'd2: begin
              pend_d  = uProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            4'd3: begin
              pend_d  = (bus.B == 32'h0) ? {hi_q, lo_q} : {sRem, sQuot};
              cnt_d   = CW'(DIV_LAT);
              state_d = RUN;
            end
            4'd4: begin
              pend_d  = (bus.B == 32'h0) ? {hi_q, lo_q} : {uRem, uQuot};
              cnt_d   = CW'(DIV_LAT);
              state_d = RUN;
            end
            4'd5: hi_d = bus.A;
            4'd6: lo_d = bus.A;
`ifdef MDU_MADD_EN
            4'd9: begin
              pend_d  = {hi_q, lo_q} + sProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            4'd10: begin
              pend_d  = {hi_q, lo_q} + uProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            4'd11: begin
              pend_d  = {hi_q, lo_q} - sProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            4'd12: begin
              pend_d  = {hi_q, lo_q} - uProd;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo.
// It runs a linear sequence of directed steps, followed by random traffic.
// Every cycle is compared against an arithmetic reference model of HI/LO and Busy.
module tb_mdu_hilo;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Reference model state: architectural HI/LO, result waiting to commit, cycles of Busy left.
  logic [31:0] mHi, mLo;
  logic [63:0] mPend;
  int          mLeft;

  mdu_hilo_if bus();

  mdu_hilo #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic modelStep(input logic r, input logic st, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (r) begin
      mHi = 0; mLo = 0; mPend = 0; mLeft = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) {mHi, mLo} = mPend;
    end else if (st) begin
      case (op)
        4'd1: begin mPend = 64'(sa * sb); mLeft = MULT_LAT; end
        4'd2: begin mPend = ua * ub; mLeft = MULT_LAT; end
        4'd3: begin
          if (b == 0) mPend = {mHi, mLo};
          else mPend = {32'(sa % sb), 32'(sa / sb)};
          mLeft = DIV_LAT;
        end
        4'd4: begin
          if (b == 0) mPend = {mHi, mLo};
          else mPend = {32'(ua % ub), 32'(ua / ub)};
          mLeft = DIV_LAT;
        end
        4'd5: mHi = a;
        4'd6: mLo = a;
`ifdef MDU_MADD_EN
        4'd9:  begin mPend = {mHi, mLo} + 64'(sa * sb); mLeft = MULT_LAT; end
        4'd10: begin mPend = {mHi, mLo} + ua * ub;      mLeft = MULT_LAT; end
        4'd11: begin mPend = {mHi, mLo} - 64'(sa * sb); mLeft = MULT_LAT; end
        4'd12: begin mPend = {mHi, mLo} - ua * ub;      mLeft = MULT_LAT; end
`endif
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, then compare the outputs 1 unit later.
  task automatic applyStimulus(input logic r, input logic st, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    rst = r;
    bus.Start = st;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    modelStep(r, st, op, a, b);
    #1;
    checkOutput("busy", {31'h0, bus.Busy}, {31'h0, (mLeft > 0)});
    checkOutput("hi", bus.HI, mHi);
    checkOutput("lo", bus.LO, mLo);
  endtask

  // Run n cycles with no reset and no Start.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
  endtask

  // Directed steps followed by random traffic.
  initial begin
    logic [3:0]  rOp;
    logic [31:0] rA, rB;
    logic        rSt, rR;
    total = 0;
    bad = 0;
    mHi = 0; mLo = 0; mPend = 0; mLeft = 0;
    rst = 1'b1;
    bus.Start = 1'b0; bus.Op = 4'd0; bus.A = 32'h0; bus.B = 32'h0;
    $display("[TB] starting mdu_hilo bench");

    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'd1, 32'h5, 32'h7);
    checkOutput("reset_busy", {31'h0, bus.Busy}, 32'h0);
    checkOutput("reset_hi", bus.HI, 32'h0);

    applyStimulus(1'b0, 1'b1, 4'd1, 32'hFFFFFFFF, 32'h2);
    idle(MULT_LAT);
    checkOutput("mult_hi", bus.HI, 32'hFFFFFFFF);
    checkOutput("mult_lo", bus.LO, 32'hFFFFFFFE);
    applyStimulus(1'b0, 1'b1, 4'd2, 32'hFFFFFFFF, 32'h2);
    idle(MULT_LAT);
    checkOutput("multu_hi", bus.HI, 32'h1);
    checkOutput("multu_lo", bus.LO, 32'hFFFFFFFE);

    applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFFFFF9, 32'h2);
    idle(DIV_LAT);
    checkOutput("div_hi", bus.HI, 32'hFFFFFFFF);
    checkOutput("div_lo", bus.LO, 32'hFFFFFFFD);
    applyStimulus(1'b0, 1'b1, 4'd4, 32'h7, 32'h2);
    idle(DIV_LAT);
    checkOutput("divu_hi", bus.HI, 32'h1);
    checkOutput("divu_lo", bus.LO, 32'h3);
    applyStimulus(1'b0, 1'b1, 4'd3, 32'h1234, 32'h0);
    idle(DIV_LAT);
    checkOutput("div0_hi", bus.HI, 32'h1);
    checkOutput("div0_lo", bus.LO, 32'h3);
    applyStimulus(1'b0, 1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(DIV_LAT);
    checkOutput("divovf_hi", bus.HI, 32'h0);
    checkOutput("divovf_lo", bus.LO, 32'h80000000);

    applyStimulus(1'b0, 1'b1, 4'd5, 32'h12345678, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd6, 32'h9ABCDEF0, 32'h0);
    checkOutput("mt_hi", bus.HI, 32'h12345678);
    checkOutput("mt_lo", bus.LO, 32'h9ABCDEF0);

    applyStimulus(1'b0, 1'b1, 4'd4, 32'd100, 32'd7);
    applyStimulus(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd1, 32'h3, 32'h3);
    idle(DIV_LAT - 2);
    checkOutput("busy_ign_hi", bus.HI, 32'd2);
    checkOutput("busy_ign_lo", bus.LO, 32'd14);

    applyStimulus(1'b0, 1'b1, 4'd3, 32'd50, 32'd3);
    idle(2);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    checkOutput("rst_mid_busy", {31'h0, bus.Busy}, 32'h0);
    idle(DIV_LAT + 2);
    checkOutput("rst_mid_lo", bus.LO, 32'h0);

    applyStimulus(1'b0, 1'b1, 4'd6, 32'd5, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd5, 32'd0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd9, 32'd3, 32'd4);
    idle(MULT_LAT);
`ifdef MDU_MADD_EN
    checkOutput("madd_hi", bus.HI, 32'h0);
    checkOutput("madd_lo", bus.LO, 32'd17);
`else
    checkOutput("madd_off_lo", bus.LO, 32'd5);
`endif
    applyStimulus(1'b0, 1'b1, 4'd12, 32'd1, 32'd18);
    idle(MULT_LAT);
`ifdef MDU_MADD_EN
    checkOutput("msubu_hi", bus.HI, 32'hFFFFFFFF);
    checkOutput("msubu_lo", bus.LO, 32'hFFFFFFFF);
`else
    checkOutput("msubu_off_lo", bus.LO, 32'd5);
`endif

    for (int i = 0; i < 400; i++) begin
      rOp = 4'($urandom_range(0, 15));
      rA  = $urandom;
      rB  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rB = 32'($urandom_range(1, 9));
      rSt = ($urandom_range(0, 3) != 0);
      rR  = ($urandom_range(0, 60) == 0);
      applyStimulus(rR, rSt, rOp, rA, rB);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
